spi_slave_core: RTL and testbench

Parametrised SPI slave that replaces the fixed 8-bit, mode-0, echo-only slave. It provides a configurable word width, all four CPOL/CPHA modes, and MSB- or LSB-first bit order. Transfers are framed by chip-select, and back-to-back words are supported within one frame. A parallel RX strobe and a single-entry TX buffer with a valid/ready handshake connect it to fabric logic running on the internal oscillator clock.

---
 rtl/spi_slave_core.sv | 211 +++++++++++++++++++++
 tb/tb_spi_slave_core.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_core.sv
// ---------------------------------------------------------------------------
// spi_slave_core
//
// Parametrised SPI slave. It supports a configurable word width, all four
// CPOL/CPHA modes and MSB- or LSB-first bit order. Frames are delimited by
// SPI_CE, and several words may follow each other inside one frame. All SPI
// inputs are resynchronised into clk, so clk must run at least 4x SCLK.
//
// Ports
//   clk, rst_n    fabric clock, asynchronous active-low reset
//   SPI_SCLK      SPI clock from the master
//   SPI_MOSI      master-out data
//   SPI_CE        chip-select, active-low
//   SPI_MISO      slave-out data, forced to 0 while the output is disabled
//   miso_oe       MISO drive enable; high while a frame is active
//   rx_data       last complete received word
//   rx_valid      one-cycle strobe that marks an rx_data update
//   tx_data       word offered for transmission
//   tx_valid      tx_data is offered
//   tx_ready      single-entry TX buffer is empty
//   tx_underrun   one-cycle strobe; DEFAULT_TX was sent instead of buffer data
//   busy          frame active
//   state_dbg     current FSM state (IDLE=0, LOAD=1, SHIFT=2)
//
// TX handshake: a word transfers on every clk edge where tx_valid && tx_ready.
// tx_valid may be raised at any time and is held until accepted. tx_ready
// depends only on the buffer state and never on tx_valid.
// ---------------------------------------------------------------------------
module spi_slave_core #(
    parameter int               WIDTH      = 8,
    parameter bit               CPOL       = 1'b0,
    parameter bit               CPHA       = 1'b0,
    parameter bit               MSB_FIRST  = 1'b1,
    parameter int               SYNC       = 2,
    parameter logic [WIDTH-1:0] DEFAULT_TX = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             SPI_SCLK,
    input  logic             SPI_MOSI,
    input  logic             SPI_CE,
    output logic             SPI_MISO,
    output logic             miso_oe,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             tx_underrun,
    output logic             busy,
    output logic [1:0]       state_dbg
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    state_t state, state_nx;

    // ---------------- input synchronisers ----------------
    // The CE chain clears to 0 on reset. A CE that is still low when reset is
    // released therefore does not look like a falling edge. The slave waits
    // for CE to go high and then low again.
    logic [SYNC-1:0] sclk_sr, mosi_sr, ce_sr;
    logic            sclk_prev, ce_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sr   <= '0;
            mosi_sr   <= '0;
            ce_sr     <= '0;
            sclk_prev <= 1'b0;
            ce_prev   <= 1'b0;
        end else begin
            sclk_sr   <= {sclk_sr[SYNC-2:0], SPI_SCLK};
            mosi_sr   <= {mosi_sr[SYNC-2:0], SPI_MOSI};
            ce_sr     <= {ce_sr[SYNC-2:0], SPI_CE};
            sclk_prev <= sclk_sr[SYNC-1];
            ce_prev   <= ce_sr[SYNC-1];
        end
    end

    logic sclk_s, mosi_s, ce_s;
    assign sclk_s = sclk_sr[SYNC-1];
    assign mosi_s = mosi_sr[SYNC-1];
    assign ce_s   = ce_sr[SYNC-1];

    logic sclk_rise, sclk_fall, lead_edge, trail_edge, sample_edge, shift_edge;
    logic ce_fall;
    assign sclk_rise   = sclk_s & ~sclk_prev;
    assign sclk_fall   = ~sclk_s & sclk_prev;
    assign lead_edge   = CPOL ? sclk_fall : sclk_rise;
    assign trail_edge  = CPOL ? sclk_rise : sclk_fall;
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge : trail_edge;
    assign ce_fall     = ce_prev & ~ce_s;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (ce_fall) state_nx = ST_LOAD;
            ST_LOAD:  state_nx = ce_s ? ST_IDLE : ST_SHIFT;
            ST_SHIFT: if (ce_s) state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // ---------------- datapath control ----------------
    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] rx_sr, tx_sr, tx_buf, rx_next;
    logic             buf_full;
    logic             reload_pend;   // a word just finished; the next shift edge reloads
    logic             spec_pend;     // reloaded word not yet committed
    logic             spec_from_buf; // that reload came from the buffer

    logic in_shift, do_load, do_sample, do_reload, do_advance, word_done, commit;
    logic pop_buf, tx_wr;

    assign in_shift   = (state == ST_SHIFT) && !ce_s;
    assign do_load    = (state == ST_LOAD);
    assign do_sample  = in_shift && sample_edge;
    assign do_reload  = in_shift && shift_edge && reload_pend;
    // With CPHA=1 the first leading edge of a word comes before any sample
    // (bit_cnt==0), so it must not advance the output. With CPHA=0 a shift
    // edge never arrives at bit_cnt==0 unless a reload is pending.
    assign do_advance = in_shift && shift_edge && !reload_pend && (bit_cnt != '0);
    assign word_done  = do_sample && (bit_cnt == CW'(WIDTH - 1));

    // A reload only presents the next word's first bit. The buffer is popped
    // (or the underrun is reported) once the first sample edge of that word
    // arrives. In mode 0 the edge that returns SCLK to idle after the last
    // word would otherwise consume a TX word for a word that never starts.
    assign commit  = do_sample && spec_pend;
    assign pop_buf = (do_load && buf_full) || (commit && spec_from_buf);
    assign tx_wr   = tx_valid && !buf_full;

    assign rx_next = MSB_FIRST ? {rx_sr[WIDTH-2:0], mosi_s} : {mosi_s, rx_sr[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt       <= '0;
            rx_sr         <= '0;
            tx_sr         <= '0;
            tx_buf        <= '0;
            buf_full      <= 1'b0;
            reload_pend   <= 1'b0;
            spec_pend     <= 1'b0;
            spec_from_buf <= 1'b0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            tx_underrun   <= 1'b0;
        end else begin
            rx_valid    <= word_done;
            tx_underrun <= (do_load && !buf_full) || (commit && !spec_from_buf);

            // The TX buffer is kept across a CE abort. Only a pop empties it.
            if (pop_buf) begin
                buf_full <= 1'b0;
            end else if (tx_wr) begin
                buf_full <= 1'b1;
                tx_buf   <= tx_data;
            end

            if (!in_shift) begin
                bit_cnt     <= '0;
                reload_pend <= 1'b0;
                spec_pend   <= 1'b0;
            end else begin
                if (do_sample) begin
                    rx_sr   <= rx_next;
                    bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
                end
                if (word_done) begin
                    rx_data     <= rx_next;
                    reload_pend <= 1'b1;
                end else if (do_reload) begin
                    reload_pend <= 1'b0;
                end
                if (do_reload) begin
                    spec_pend     <= 1'b1;
                    spec_from_buf <= buf_full;
                end else if (commit) begin
                    spec_pend <= 1'b0;
                end
            end

            if (do_load || do_reload) begin
                tx_sr <= buf_full ? tx_buf : DEFAULT_TX;
            end else if (do_advance) begin
                tx_sr <= MSB_FIRST ? {tx_sr[WIDTH-2:0], 1'b0} : {1'b0, tx_sr[WIDTH-1:1]};
            end
        end
    end

    assign busy      = (state != ST_IDLE);
    assign miso_oe   = busy;
    assign SPI_MISO  = miso_oe & (MSB_FIRST ? tx_sr[WIDTH-1] : tx_sr[0]);
    assign tx_ready  = !buf_full;
    assign state_dbg = state;

endmodule

// File: tb/tb_spi_slave_core.sv
// ---------------------------------------------------------------------------
// tb_spi_slave_core
//
// Two instances run side by side:
//   u0  WIDTH=8,  mode 0, MSB first
//   u1  WIDTH=16, mode 3, LSB first
// The bench plays the SPI master for both. A word-level model predicts
// the following from the master's view of each frame:
//   - rx words: an expected queue, checked on every rx_valid strobe
//   - MISO words: the FIFO of written TX words, or the all-ones default
//   - the number of underrun strobes
// ---------------------------------------------------------------------------
module tb_spi_slave_core;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        sclk0, mosi0, ce0, miso0, oe0, rxv0, txv0, txr0, urun0, busy0;
  logic [7:0]  rxd0, txd0;
  logic [1:0]  st0;
  logic        sclk1, mosi1, ce1, miso1, oe1, rxv1, txv1, txr1, urun1, busy1;
  logic [15:0] rxd1, txd1;
  logic [1:0]  st1;

  spi_slave_core #(.WIDTH(8)) u0 (
    .clk(clk), .rst_n(rst_n), .SPI_SCLK(sclk0), .SPI_MOSI(mosi0), .SPI_CE(ce0),
    .SPI_MISO(miso0), .miso_oe(oe0), .rx_data(rxd0), .rx_valid(rxv0),
    .tx_data(txd0), .tx_valid(txv0), .tx_ready(txr0), .tx_underrun(urun0),
    .busy(busy0), .state_dbg(st0)
  );

  spi_slave_core #(.WIDTH(16), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .SPI_SCLK(sclk1), .SPI_MOSI(mosi1), .SPI_CE(ce1),
    .SPI_MISO(miso1), .miso_oe(oe1), .rx_data(rxd1), .rx_valid(rxv1),
    .tx_data(txd1), .tx_valid(txv1), .tx_ready(txr1), .tx_underrun(urun1),
    .busy(busy1), .state_dbg(st1)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q0[$], exp_q1[$];  // expected rx words
  logic [15:0] tx_q0[$], tx_q1[$];    // words written but not yet sent
  int exp_urun[2];
  int seen_urun[2];

  logic [15:0] frame_mosi[8];
  logic [15:0] frame_wr[8];
  bit          frame_dowr[8];
  logic [15:0] got_w[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (rxv0) begin
        if (exp_q0.size() == 0) check("rx0_unexpected", {24'd0, rxd0}, 32'hFFFF_FFFF);
        else check("rx0_data", {24'd0, rxd0}, {24'd0, exp_q0.pop_front() & 16'h00FF});
      end
      if (rxv1) begin
        if (exp_q1.size() == 0) check("rx1_unexpected", {16'd0, rxd1}, 32'hFFFF_FFFF);
        else check("rx1_data", {16'd0, rxd1}, {16'd0, exp_q1.pop_front()});
      end
      if (urun0) seen_urun[0]++;
      if (urun1) seen_urun[1]++;
    end
  end

  // ---------------- pin helpers ----------------
  task automatic half_period();
    repeat (4) @(negedge clk);
  endtask

  task automatic set_sclk(input int d, input logic v);
    if (d == 0) sclk0 = v; else sclk1 = v;
  endtask

  task automatic set_mosi(input int d, input logic v);
    if (d == 0) mosi0 = v; else mosi1 = v;
  endtask

  task automatic set_ce(input int d, input logic v);
    if (d == 0) ce0 = v; else ce1 = v;
  endtask

  function automatic logic get_miso(input int d);
    return (d == 0) ? miso0 : miso1;
  endfunction

  function automatic logic get_busy(input int d);
    return (d == 0) ? busy0 : busy1;
  endfunction

  function automatic logic get_ready(input int d);
    return (d == 0) ? txr0 : txr1;
  endfunction

  // One SPI bit as the master sees it: MOSI is set up half a period before
  // the sample edge, and MISO is captured just before that edge.
  task automatic spi_bit(input int d, input logic mb, output logic sb);
    logic cpol, cpha;
    cpol = (d == 1);
    cpha = (d == 1);
    if (!cpha) begin
      set_mosi(d, mb);
      half_period();
      sb = get_miso(d);
      set_sclk(d, !cpol);
      half_period();
      set_sclk(d, cpol);
    end else begin
      set_sclk(d, !cpol);
      set_mosi(d, mb);
      half_period();
      sb = get_miso(d);
      set_sclk(d, cpol);
      half_period();
    end
  endtask

  task automatic tx_write(input int d, input logic [15:0] v);
    int n = 0;
    while (!get_ready(d) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("tx_ready_wait", {31'd0, get_ready(d)}, 32'd1);
    if (d == 0) begin txd0 = v[7:0]; txv0 = 1'b1; end
    else begin txd1 = v; txv1 = 1'b1; end
    @(negedge clk);
    txv0 = 1'b0;
    txv1 = 1'b0;
    if (d == 0) tx_q0.push_back(v & 16'h00FF); else tx_q1.push_back(v);
  endtask

  task automatic clear_frame();
    for (int i = 0; i < 8; i++) begin
      frame_mosi[i] = '0;
      frame_wr[i]   = '0;
      frame_dowr[i] = 1'b0;
      got_w[i]      = '0;
    end
  endtask

  // Runs one CE frame of nwords. If abort_bits > 0, the last word is cut off
  // after that many bits. frame_dowr[k] writes frame_wr[k] during word k-1,
  // or before CE for k=0. frame_dowr[nwords] writes during an aborted word.
  task automatic run_frame(input int d, input int nwords, input int abort_bits);
    int w, nb, idx;
    logic msb, sb;
    logic [15:0] exp_tx, got, dflt;
    w    = (d == 0) ? 8 : 16;
    msb  = (d == 0);
    dflt = (d == 0) ? 16'h00FF : 16'hFFFF;
    if (frame_dowr[0]) tx_write(d, frame_wr[0]);
    set_ce(d, 1'b0);
    repeat (8) @(negedge clk);
    check("busy_in_frame", {31'd0, get_busy(d)}, 32'd1);
    for (int k = 0; k < nwords; k++) begin
      nb = (k == nwords - 1 && abort_bits > 0) ? abort_bits : w;
      if (d == 0) begin
        if (tx_q0.size() > 0) exp_tx = tx_q0.pop_front();
        else begin exp_tx = dflt; exp_urun[0]++; end
        if (nb == w) exp_q0.push_back(frame_mosi[k] & 16'h00FF);
      end else begin
        if (tx_q1.size() > 0) exp_tx = tx_q1.pop_front();
        else begin exp_tx = dflt; exp_urun[1]++; end
        if (nb == w) exp_q1.push_back(frame_mosi[k]);
      end
      got = '0;
      for (int i = 0; i < nb; i++) begin
        idx = msb ? (w - 1 - i) : i;
        spi_bit(d, frame_mosi[k][idx], sb);
        got[idx] = sb;
        if (i == 2 && frame_dowr[k+1] && (k + 1 < nwords || nb < w))
          tx_write(d, frame_wr[k+1]);
      end
      if (nb == w) begin
        got_w[k] = got;
        check("miso_word", {16'd0, got}, {16'd0, exp_tx});
      end
    end
    repeat (8) @(negedge clk);
    set_ce(d, 1'b1);
    repeat (12) @(negedge clk);
    check("underrun_count", seen_urun[d], exp_urun[d]);
    check("rx_all_seen", (d == 0) ? exp_q0.size() : exp_q1.size(), 0);
    check("busy_after_frame", {31'd0, get_busy(d)}, 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic sb;
    int d, nw, ab;
    sclk0 = 1'b0; mosi0 = 1'b0; ce0 = 1'b1; txv0 = 1'b0; txd0 = '0;
    sclk1 = 1'b1; mosi1 = 1'b0; ce1 = 1'b1; txv1 = 1'b0; txd1 = '0;
    exp_urun[0] = 0; exp_urun[1] = 0; seen_urun[0] = 0; seen_urun[1] = 0;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);

    // Reset state
    check("rst_tx_ready0", {31'd0, txr0}, 32'd1);
    check("rst_busy0", {31'd0, busy0}, 32'd0);
    check("rst_oe0", {31'd0, oe0}, 32'd0);
    check("rst_miso0", {31'd0, miso0}, 32'd0);
    check("rst_rx_data0", {24'd0, rxd0}, 32'd0);
    check("rst_rx_valid0", {31'd0, rxv0}, 32'd0);
    check("rst_underrun0", {31'd0, urun0}, 32'd0);
    check("rst_tx_ready1", {31'd0, txr1}, 32'd1);
    check("rst_busy1", {31'd0, busy1}, 32'd0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    // Mode 0: TX 0xA5, master sends 0x3C
    clear_frame();
    frame_dowr[0] = 1'b1; frame_wr[0] = 16'h00A5; frame_mosi[0] = 16'h003C;
    run_frame(0, 1, 0);
    check("t1_master_reads", {16'd0, got_w[0]}, 32'h00A5);
    check("t1_rx_data", {24'd0, rxd0}, 32'h3C);
    check("t1_no_underrun", seen_urun[0], 0);

    // Underrun: no write, master sends 0x00
    clear_frame();
    run_frame(0, 1, 0);
    check("t2_master_reads", {16'd0, got_w[0]}, 32'h00FF);
    check("t2_underrun_once", seen_urun[0], 1);

    // Back-to-back: 0x11 then 0x22 written mid-word; master sends 0xDE, 0xAD
    clear_frame();
    frame_dowr[0] = 1'b1; frame_wr[0] = 16'h0011;
    frame_dowr[1] = 1'b1; frame_wr[1] = 16'h0022;
    frame_mosi[0] = 16'h00DE; frame_mosi[1] = 16'h00AD;
    run_frame(0, 2, 0);
    check("t3_word0", {16'd0, got_w[0]}, 32'h0011);
    check("t3_word1", {16'd0, got_w[1]}, 32'h0022);
    check("t3_rx_last", {24'd0, rxd0}, 32'hAD);

    // Abort after 5 bits. A write landing during the aborted word must survive.
    clear_frame();
    frame_dowr[0] = 1'b1; frame_wr[0] = 16'h0033; frame_mosi[0] = 16'h00F0;
    frame_dowr[1] = 1'b1; frame_wr[1] = 16'h009C;
    run_frame(0, 1, 5);
    check("t4_rx_unchanged", {24'd0, rxd0}, 32'hAD);
    check("t4_buffer_kept", {31'd0, txr0}, 32'd0);
    clear_frame();
    frame_mosi[0] = 16'h0081;
    run_frame(0, 1, 0);
    check("t4_next_rx", {24'd0, rxd0}, 32'h81);
    check("t4_next_miso", {16'd0, got_w[0]}, 32'h009C);

    // Mode 3, WIDTH=16, LSB first
    clear_frame();
    frame_dowr[0] = 1'b1; frame_wr[0] = 16'h1234; frame_mosi[0] = 16'hBEEF;
    run_frame(1, 1, 0);
    check("t5_rx_data", {16'd0, rxd1}, 32'hBEEF);
    check("t5_master_reads", {16'd0, got_w[0]}, 32'h1234);

    // Reset in the middle of a word, with a full TX buffer
    tx_write(0, 16'h005A);
    ce0 = 1'b0;
    repeat (8) @(negedge clk);
    void'(tx_q0.pop_front());
    for (int i = 0; i < 3; i++) spi_bit(0, 1'b1, sb);
    tx_write(0, 16'h006B);
    check("t6_buffer_full", {31'd0, txr0}, 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_rst_tx_ready", {31'd0, txr0}, 32'd1);
    check("t6_rst_busy", {31'd0, busy0}, 32'd0);
    check("t6_rst_oe", {31'd0, oe0}, 32'd0);
    check("t6_rst_miso", {31'd0, miso0}, 32'd0);
    check("t6_rst_rx_data", {24'd0, rxd0}, 32'd0);
    tx_q0.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    // CE still low at release: a whole word of clocks must be ignored
    for (int i = 0; i < 8; i++) spi_bit(0, 1'b1, sb);
    check("t6_ce_low_ignored_busy", {31'd0, busy0}, 32'd0);
    check("t6_ce_low_ignored_miso", {31'd0, miso0}, 32'd0);
    ce0 = 1'b1;
    repeat (8) @(negedge clk);
    clear_frame();
    frame_dowr[0] = 1'b1; frame_wr[0] = 16'h00C3; frame_mosi[0] = 16'h0096;
    run_frame(0, 1, 0);
    check("t6_after_rst_rx", {24'd0, rxd0}, 32'h96);
    check("t6_after_rst_miso", {16'd0, got_w[0]}, 32'h00C3);

    // Randomised frames on both instances
    for (int f = 0; f < 24; f++) begin
      d  = $urandom_range(0, 1);
      nw = $urandom_range(1, 3);
      ab = ($urandom_range(0, 4) == 0) ? $urandom_range(4, (d == 0) ? 7 : 15) : 0;
      clear_frame();
      for (int k = 0; k <= nw; k++) begin
        frame_mosi[k] = $urandom_range(0, 16'hFFFF);
        frame_wr[k]   = $urandom_range(0, 16'hFFFF);
        if (d == 0) begin
          frame_mosi[k] = frame_mosi[k] & 16'h00FF;
          frame_wr[k]   = frame_wr[k] & 16'h00FF;
        end
        frame_dowr[k] = $urandom_range(0, 1);
      end
      if ((d == 0 && tx_q0.size() > 0) || (d == 1 && tx_q1.size() > 0)) frame_dowr[0] = 1'b0;
      run_frame(d, nw, ab);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
